// File: rtl/alarm_melody_seq.sv
// alarm_melody_seq
//   Plays a fixed 13-entry melody from a small ROM as a sequence of one-hot
//   note codes plus a tone enable. Each note is followed by a short silent
//   articulation gap; rests are silent for their full length. The melody
//   repeats REPEAT times per alarm, then the block returns to idle.
//
//   Optional feature (compile-time macro ALARM_SNOOZE_EN): a snooze request
//   silences the alarm for SNOOZE_BEATS beats, after which the melody restarts
//   from the top with a fresh repeat count. Without the macro the SNOOZE input
//   is accepted but has no effect, and no snooze state or counter exists.
//
// Ports
//   CLOCK     in   sole clock
//   RST       in   synchronous reset, active high
//   ALM_TRIG  in   start request (level, ignored while busy)
//   ALM_STOP  in   stop request (level, highest priority after RST)
//   SNOOZE    in   snooze request (only meaningful with ALARM_SNOOZE_EN)
//   music     out  one-hot note code, bit0 = DO ... bit7 = DO1
//   ALM       out  tone enable, 1 = sound
//   BUSY      out  high whenever the sequencer is not idle
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for ALM_TRIG, all outputs low
// S_NOTE  | playing a note (ALM=1) or holding a rest (ALM=0)
// S_GAP   | articulation gap after a note, ALM=0, music unchanged
// S_END   | one-cycle end-of-pass marker, bumps the repeat count
// S_SNOOZE| silent snooze period (ALARM_SNOOZE_EN builds only)

module alarm_melody_seq #(
  parameter int BEAT_DIV     = 6250000,
  parameter int GAP_CYCLES   = 625000,
  parameter int REPEAT       = 4,
  parameter int SNOOZE_BEATS = 2400
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       ALM_TRIG,
  input  logic       ALM_STOP,
  input  logic       SNOOZE,
  output logic [7:0] music,
  output logic       ALM,
  output logic       BUSY
);

  // Longest entry is 4 beats; keep at least 25 bits regardless.
  localparam int CNT_W = ($clog2(4 * BEAT_DIV) > 25) ? $clog2(4 * BEAT_DIV) : 25;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_L    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_L   = CNT_W'(BEAT_DIV);
  localparam logic [3:0]       REPEAT_L = 4'(REPEAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NOTE,
    S_GAP,
`ifdef ALARM_SNOOZE_EN
    S_SNOOZE,
`endif
    S_END
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [3:0]       rpt, rpt_nxt;
  logic [3:0]       rpt_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       music_nxt;
  logic             alm_nxt;
  logic             busy_nxt;

  logic             ld;
  logic [3:0]       ld_idx;
  logic [5:0]       entry;
  logic [CNT_W-1:0] len;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = ($clog2(SNOOZE_BEATS + 1) > 1) ? $clog2(SNOOZE_BEATS + 1) : 1;
  localparam logic [SNZ_W-1:0] SNZ_L = SNZ_W'(SNOOZE_BEATS);

  // Snooze is timed as whole beats: cnt counts one beat, snz_cnt counts beats.
  logic [SNZ_W-1:0] snz_cnt, snz_nxt;
`else
  logic unused_snooze;
  assign unused_snooze = SNOOZE;
`endif

  // {note[3:0], dur[1:0]}; note 0 = rest, 15 = end marker, dur d = d+1 beats
  function automatic logic [5:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = {4'd1,  2'd0};
      4'd1:    rom = {4'd3,  2'd0};
      4'd2:    rom = {4'd5,  2'd0};
      4'd3:    rom = {4'd8,  2'd1};
      4'd4:    rom = {4'd5,  2'd0};
      4'd5:    rom = {4'd3,  2'd0};
      4'd6:    rom = {4'd1,  2'd1};
      4'd7:    rom = {4'd0,  2'd0};
      4'd8:    rom = {4'd8,  2'd0};
      4'd9:    rom = {4'd8,  2'd0};
      4'd10:   rom = {4'd8,  2'd1};
      4'd11:   rom = {4'd0,  2'd1};
      default: rom = {4'd15, 2'd0};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] beat_len(input logic [1:0] d);
    case (d)
      2'd0:    beat_len = CNT_W'(BEAT_DIV);
      2'd1:    beat_len = CNT_W'(2 * BEAT_DIV);
      2'd2:    beat_len = CNT_W'(3 * BEAT_DIV);
      default: beat_len = CNT_W'(4 * BEAT_DIV);
    endcase
  endfunction

  assign rpt_inc = rpt + 4'd1;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rpt_nxt   = rpt;
    cnt_nxt   = cnt;
    music_nxt = music;
    alm_nxt   = ALM;
    busy_nxt  = BUSY;
    ld        = 1'b0;
    ld_idx    = idx + 4'd1;
    entry     = '0;
    len       = '0;
`ifdef ALARM_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (ALM_TRIG && !ALM_STOP) begin
          ld      = 1'b1;
          ld_idx  = 4'd0;
          rpt_nxt = 4'd0;
        end
      end
      S_NOTE: begin
        if (cnt == '0) begin
          // ALM high here means a sounding note (rests hold ALM low), so only
          // notes get the articulation gap.
          if (ALM && (GAP_CYCLES > 0)) begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_L - ONE;
            alm_nxt   = 1'b0;
          end else begin
            ld = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      S_GAP: begin
        if (cnt == '0) ld = 1'b1;
        else           cnt_nxt = cnt - ONE;
      end
      S_END: begin
        rpt_nxt = rpt_inc;
        if (rpt_inc < REPEAT_L) begin
          ld     = 1'b1;
          ld_idx = 4'd0;
        end else begin
          state_nxt = S_IDLE;
          idx_nxt   = 4'd0;
          cnt_nxt   = '0;
          music_nxt = 8'h00;
          alm_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (cnt == '0) begin
          if (snz_cnt == '0) begin
            ld      = 1'b1;
            ld_idx  = 4'd0;
            rpt_nxt = 4'd0;
          end else begin
            snz_nxt = snz_cnt - SNZ_W'(1);
            cnt_nxt = BEAT_L - ONE;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Entry load: the counter holds cycles remaining minus one.
    if (ld) begin
      entry    = rom(ld_idx);
      len      = beat_len(entry[1:0]);
      idx_nxt  = ld_idx;
      busy_nxt = 1'b1;
      if (entry[5:2] == 4'd15) begin
        state_nxt = S_END;
        cnt_nxt   = '0;
        alm_nxt   = 1'b0;
      end else if ((entry[5:2] >= 4'd1) && (entry[5:2] <= 4'd8)) begin
        state_nxt = S_NOTE;
        cnt_nxt   = len - GAP_L - ONE;
        alm_nxt   = 1'b1;
        music_nxt = 8'd1 << (entry[5:2] - 4'd1);
      end else begin
        state_nxt = S_NOTE;
        cnt_nxt   = len - ONE;
        alm_nxt   = 1'b0;
      end
    end

`ifdef ALARM_SNOOZE_EN
    if (SNOOZE && ((state == S_NOTE) || (state == S_GAP) || (state == S_END))) begin
      state_nxt = S_SNOOZE;
      idx_nxt   = idx;
      rpt_nxt   = rpt;
      cnt_nxt   = BEAT_L - ONE;
      snz_nxt   = SNZ_L - SNZ_W'(1);
      music_nxt = 8'h00;
      alm_nxt   = 1'b0;
      busy_nxt  = 1'b1;
    end
`endif

    if (ALM_STOP && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      idx_nxt   = 4'd0;
      rpt_nxt   = 4'd0;
      cnt_nxt   = '0;
      music_nxt = 8'h00;
      alm_nxt   = 1'b0;
      busy_nxt  = 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_nxt   = '0;
`endif
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state <= S_IDLE;
      idx   <= 4'd0;
      rpt   <= 4'd0;
      cnt   <= '0;
      music <= 8'h00;
      ALM   <= 1'b0;
      BUSY  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rpt   <= rpt_nxt;
      cnt   <= cnt_nxt;
      music <= music_nxt;
      ALM   <= alm_nxt;
      BUSY  <= busy_nxt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= snz_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_melody_seq.sv
// Testbench for alarm_melody_seq with BEAT_DIV=10, GAP_CYCLES=2, REPEAT=2,
// SNOOZE_BEATS=3. Stimulus pushes (edge, expected outputs) records into a
// queue; a monitor samples the outputs on every falling edge and pops and
// compares each record when its edge comes up.
// "Edge k" = the k-th rising edge counted from the test's base; inputs for
// "edge k" are driven just after that edge and sampled at edge k+1.

module tb_alarm_melody_seq;

  logic       CLOCK    = 1'b0;
  logic       RST      = 1'b1;
  logic       ALM_TRIG = 1'b0;
  logic       ALM_STOP = 1'b0;
  logic       SNOOZE   = 1'b0;
  logic [7:0] music;
  logic       ALM;
  logic       BUSY;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         e;
    logic [7:0] m;
    logic       a;
    logic       b;
    string      nm;
  } exp_t;

  exp_t sb[$];

  alarm_melody_seq #(
    .BEAT_DIV    (10),
    .GAP_CYCLES  (2),
    .REPEAT      (2),
    .SNOOZE_BEATS(3)
  ) dut (
    .CLOCK   (CLOCK),
    .RST     (RST),
    .ALM_TRIG(ALM_TRIG),
    .ALM_STOP(ALM_STOP),
    .SNOOZE  (SNOOZE),
    .music   (music),
    .ALM     (ALM),
    .BUSY    (BUSY)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic expect_at(input int e, input logic [7:0] m, input logic a,
                           input logic b, input string nm);
    exp_t x;
    x.e = e; x.m = m; x.a = a; x.b = b; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset(output int r);
    RST = 1'b1;
    wait_edge(cyc + 1);
    RST = 1'b0;
    r = cyc;
    expect_at(r, 8'h00, 1'b0, 1'b0, "reset_state");
  endtask

  task automatic trigger(input int b);
    wait_edge(b);
    ALM_TRIG = 1'b1;
    wait_edge(b + 1);
    ALM_TRIG = 1'b0;
  endtask

  // Monitor / scoreboard checker
  initial begin
    exp_t x;
    forever begin
      @(negedge CLOCK);
      while (sb.size() > 0 && sb[0].e <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.e != cyc) begin
          errors++;
          $display("FAIL %s: sample for edge %0d missed (now edge %0d)", x.nm, x.e, cyc);
        end else if (music !== x.m || ALM !== x.a || BUSY !== x.b) begin
          errors++;
          $display("FAIL %s @edge %0d: got music=%02h ALM=%b BUSY=%b, want music=%02h ALM=%b BUSY=%b",
                   x.nm, cyc, music, ALM, BUSY, x.m, x.a, x.b);
        end
      end
    end
  end

  initial begin
    int r;
    int b;

    // Test 1: single trigger, full two-pass melody, retrigger while busy
    do_reset(r);
    b = r + 1;
    expect_at(b + 1,   8'h01, 1'b1, 1'b1, "t1_first_note");
    expect_at(b + 8,   8'h01, 1'b1, 1'b1, "t1_note_last_cycle");
    expect_at(b + 9,   8'h01, 1'b0, 1'b1, "t1_gap_start");
    expect_at(b + 10,  8'h01, 1'b0, 1'b1, "t1_gap_end");
    expect_at(b + 11,  8'h04, 1'b1, 1'b1, "t1_mi");
    expect_at(b + 16,  8'h04, 1'b1, 1'b1, "t1_retrig_ignored");
    expect_at(b + 21,  8'h10, 1'b1, 1'b1, "t1_sol");
    expect_at(b + 31,  8'h80, 1'b1, 1'b1, "t1_do1_long");
    expect_at(b + 48,  8'h80, 1'b1, 1'b1, "t1_do1_last_sound");
    expect_at(b + 49,  8'h80, 1'b0, 1'b1, "t1_do1_gap");
    expect_at(b + 51,  8'h10, 1'b1, 1'b1, "t1_sol2");
    expect_at(b + 91,  8'h01, 1'b0, 1'b1, "t1_rest_beat10_start");
    expect_at(b + 100, 8'h01, 1'b0, 1'b1, "t1_rest_beat10_end");
    expect_at(b + 101, 8'h80, 1'b1, 1'b1, "t1_after_rest");
    expect_at(b + 141, 8'h80, 1'b0, 1'b1, "t1_rest_beat15");
    expect_at(b + 160, 8'h80, 1'b0, 1'b1, "t1_rest_beat16_end");
    expect_at(b + 161, 8'h80, 1'b0, 1'b1, "t1_end_marker");
    expect_at(b + 162, 8'h01, 1'b1, 1'b1, "t1_pass2_start");
    expect_at(b + 252, 8'h01, 1'b0, 1'b1, "t1_pass2_rest");
    expect_at(b + 322, 8'h80, 1'b0, 1'b1, "t1_pass2_end");
    expect_at(b + 323, 8'h00, 1'b0, 1'b0, "t1_busy_fall");
    expect_at(b + 325, 8'h00, 1'b0, 1'b0, "t1_stays_idle");
    trigger(b);
    wait_edge(b + 15);
    ALM_TRIG = 1'b1;
    wait_edge(b + 16);
    ALM_TRIG = 1'b0;
    wait_edge(b + 330);

    // Test 2: stop and trigger together mid-note
    do_reset(r);
    b = r + 1;
    expect_at(b + 5, 8'h01, 1'b1, 1'b1, "t2_before_stop");
    expect_at(b + 6, 8'h00, 1'b0, 1'b0, "t2_stop_wins");
    expect_at(b + 8, 8'h00, 1'b0, 1'b0, "t2_stays_idle");
    trigger(b);
    wait_edge(b + 5);
    ALM_STOP = 1'b1;
    ALM_TRIG = 1'b1;
    wait_edge(b + 6);
    ALM_STOP = 1'b0;
    ALM_TRIG = 1'b0;
    wait_edge(b + 10);

    // Test 3: reset mid-note, then retrigger
    do_reset(r);
    b = r + 1;
    expect_at(b + 39, 8'h80, 1'b1, 1'b1, "t3_before_rst");
    expect_at(b + 40, 8'h00, 1'b0, 1'b0, "t3_rst_mid_note");
    expect_at(b + 42, 8'h00, 1'b0, 1'b0, "t3_idle_after_rst");
    expect_at(b + 43, 8'h01, 1'b1, 1'b1, "t3_retrig");
    expect_at(b + 46, 8'h00, 1'b0, 1'b0, "t3_stop");
    trigger(b);
    wait_edge(b + 39);
    RST = 1'b1;
    wait_edge(b + 40);
    RST = 1'b0;
    wait_edge(b + 42);
    ALM_TRIG = 1'b1;
    wait_edge(b + 43);
    ALM_TRIG = 1'b0;
    wait_edge(b + 45);
    ALM_STOP = 1'b1;
    wait_edge(b + 46);
    ALM_STOP = 1'b0;

    // Test 4: snooze request mid-note (plus trigger/snooze during the period)
    do_reset(r);
    b = r + 1;
    expect_at(b + 5,  8'h01, 1'b1, 1'b1, "t4_before_snooze");
`ifdef ALARM_SNOOZE_EN
    expect_at(b + 6,  8'h00, 1'b0, 1'b1, "t4_snooze_enter");
    expect_at(b + 20, 8'h00, 1'b0, 1'b1, "t4_snooze_ignores_inputs");
    expect_at(b + 35, 8'h00, 1'b0, 1'b1, "t4_snooze_last");
    expect_at(b + 36, 8'h01, 1'b1, 1'b1, "t4_snooze_resume");
    expect_at(b + 46, 8'h04, 1'b1, 1'b1, "t4_resume_second_note");
`else
    expect_at(b + 6,  8'h01, 1'b1, 1'b1, "t4_snooze_ignored");
    expect_at(b + 9,  8'h01, 1'b0, 1'b1, "t4_gap");
    expect_at(b + 11, 8'h04, 1'b1, 1'b1, "t4_mi");
    expect_at(b + 20, 8'h04, 1'b0, 1'b1, "t4_mi_gap");
    expect_at(b + 31, 8'h80, 1'b1, 1'b1, "t4_do1");
    expect_at(b + 36, 8'h80, 1'b1, 1'b1, "t4_do1_mid");
    expect_at(b + 46, 8'h80, 1'b1, 1'b1, "t4_do1_late");
`endif
    expect_at(b + 51, 8'h00, 1'b0, 1'b0, "t4_stop");
    trigger(b);
    wait_edge(b + 5);
    SNOOZE = 1'b1;
    wait_edge(b + 6);
    SNOOZE = 1'b0;
    wait_edge(b + 19);
    ALM_TRIG = 1'b1;
    SNOOZE   = 1'b1;
    wait_edge(b + 20);
    ALM_TRIG = 1'b0;
    SNOOZE   = 1'b0;
    wait_edge(b + 50);
    ALM_STOP = 1'b1;
    wait_edge(b + 51);
    ALM_STOP = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLOCK);
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: edge %0d never sampled (run ended at edge %0d)", x.nm, x.e, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
